// File: rtl/y86_pipe_ctrl.sv
// Y86 five-stage pipeline control: hazard stall/bubble generation, run-control
// FSM (idle/run/step/halt/error) with global freeze, and saturating perf counters.
module y86_pipe_ctrl #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned STAT_W  = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ICODE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               step_mode_i,
  input  logic               step_i,
  input  logic               clear_i,
  input  logic [ICODE_W-1:0] D_icode_i,
  input  logic [ICODE_W-1:0] E_icode_i,
  input  logic [ICODE_W-1:0] M_icode_i,
  input  logic [ICODE_W-1:0] W_icode_i,
  input  logic [REG_W-1:0]   d_srcA_i,
  input  logic [REG_W-1:0]   d_srcB_i,
  input  logic [REG_W-1:0]   E_dstM_i,
  input  logic               e_cnd_i,
  input  logic [STAT_W-1:0]  m_stat_i,
  input  logic [STAT_W-1:0]  W_stat_i,
  output logic               F_stall_o,
  output logic               D_stall_o,
  output logic               E_stall_o,
  output logic               M_stall_o,
  output logic               W_stall_o,
  output logic               D_bubble_o,
  output logic               E_bubble_o,
  output logic               M_bubble_o,
  output logic               set_cc_o,
  output logic [2:0]         run_state_o,
  output logic [CNT_W-1:0]   cyc_cnt_o,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic [CNT_W-1:0]   lu_cnt_o,
  output logic [CNT_W-1:0]   mispred_cnt_o
);

  localparam logic [ICODE_W-1:0] INop    = ICODE_W'(1);
  localparam logic [ICODE_W-1:0] IMrmovq = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] IOpq    = ICODE_W'(6);
  localparam logic [ICODE_W-1:0] IJxx    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] IRet    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] IPopq   = ICODE_W'(11);
  localparam logic [REG_W-1:0]   RNone   = '1;
  localparam logic [STAT_W-1:0]  SAok    = STAT_W'(0);
  localparam logic [STAT_W-1:0]  SAdr    = STAT_W'(1);
  localparam logic [STAT_W-1:0]  SIns    = STAT_W'(2);
  localparam logic [STAT_W-1:0]  SHlt    = STAT_W'(3);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StStep = 3'd2,
    StHalt = 3'd3,
    StErr  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, lu_q, lu_d, mp_q, mp_d;

  logic load_use, ret_in, mispred, exc_m, exc_w, adv;

  // Hazard detection terms
  always_comb begin
    load_use = ((E_icode_i == IMrmovq) || (E_icode_i == IPopq)) && (E_dstM_i != RNone) &&
               ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret_in   = (D_icode_i == IRet) || (E_icode_i == IRet) || (M_icode_i == IRet);
    mispred  = (E_icode_i == IJxx) && !e_cnd_i;
    exc_m    = (m_stat_i != SAok);
    exc_w    = (W_stat_i != SAok);
    adv      = (state_q == StRun) || ((state_q == StStep) && step_i);
  end

  // Pipeline controls; a non-advancing cycle freezes every stage register
  always_comb begin
    F_stall_o  = 1'b1;
    D_stall_o  = 1'b1;
    E_stall_o  = 1'b1;
    M_stall_o  = 1'b1;
    W_stall_o  = 1'b1;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    set_cc_o   = 1'b0;
    if (adv) begin
      F_stall_o  = load_use | ret_in;
      D_stall_o  = load_use;
      E_stall_o  = 1'b0;
      M_stall_o  = 1'b0;
      W_stall_o  = exc_w;
      D_bubble_o = mispred | (ret_in & ~load_use);
      E_bubble_o = mispred | load_use;
      M_bubble_o = exc_m | exc_w;
      set_cc_o   = (E_icode_i == IOpq) & ~exc_m & ~exc_w;
    end
  end

  // Run-control next state; HALT/ERR are sticky until clear
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = step_mode_i ? StStep : StRun;
      StRun, StStep: begin
        if (adv) begin
          if (W_stat_i == SHlt) begin
            state_d = StHalt;
          end else if ((W_stat_i == SAdr) || (W_stat_i == SIns)) begin
            state_d = StErr;
          end
        end
      end
      StHalt, StErr: if (clear_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating performance counter next values
  always_comb begin
    cyc_d = sat_inc(cyc_q, adv);
    ret_d = sat_inc(ret_q, adv & ~W_stall_o & (W_stat_i == SAok) & (W_icode_i != INop));
    lu_d  = sat_inc(lu_q, adv & load_use);
    mp_d  = sat_inc(mp_q, adv & mispred);
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      ret_q   <= '0;
      lu_q    <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      lu_q    <= lu_d;
      mp_q    <= mp_d;
    end
  end

  assign run_state_o   = state_q;
  assign cyc_cnt_o     = cyc_q;
  assign retire_cnt_o  = ret_q;
  assign lu_cnt_o      = lu_q;
  assign mispred_cnt_o = mp_q;

endmodule
